// File: rtl/controlador_turnos_gato.sv
// Gato (tic-tac-toe) turn controller: grants the player on turn, validates the
// requested cell, updates the occupancy boards and evaluates win/draw.
module controlador_turnos_gato #(
  parameter logic PRIMER_TURNO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nuevo_juego,
  input  logic       jug_x_valido,
  input  logic [1:0] jug_x_fila,
  input  logic [1:0] jug_x_col,
  output logic       jug_x_ack,
  input  logic       jug_o_valido,
  input  logic [1:0] jug_o_fila,
  input  logic [1:0] jug_o_col,
  output logic       jug_o_ack,
  output logic [8:0] tablero_x,
  output logic [8:0] tablero_o,
  output logic       turno,
  output logic [1:0] estado_juego,
  output logic       error_jugada,
  output logic [3:0] movimientos
);

  typedef enum logic [2:0] {ESPERA, VALIDA, ESCRIBE, EVALUA, FIN} estado_t;

  // Eight winning lines, line gi at bits [gi*9 +: 9]: rows, columns, diagonals.
  localparam logic [71:0] LINEAS = {
    9'b001010100, 9'b100010001,
    9'b100100100, 9'b010010010, 9'b001001001,
    9'b111000000, 9'b000111000, 9'b000000111
  };

  estado_t    estado_q;
  logic [1:0] fila_q, col_q;
  logic [8:0] tab_x_q, tab_o_q;
  logic       turno_q;
  logic [1:0] resultado_q;
  logic       ack_x_q, ack_o_q, error_q;
  logic [3:0] mov_q;

  logic       sel_valido_d;
  logic [1:0] sel_fila_d, sel_col_d;
  logic [3:0] indice_d;
  logic       fuera_rango_d;
  logic [8:0] celda_d;
  logic       ilegal_d;
  logic [8:0] tab_mover_d;
  logic [7:0] linea_hit_d;
  logic       gana_d;

  assign sel_valido_d  = turno_q ? jug_o_valido : jug_x_valido;
  assign sel_fila_d    = turno_q ? jug_o_fila   : jug_x_fila;
  assign sel_col_d     = turno_q ? jug_o_col    : jug_x_col;

  assign fuera_rango_d = (fila_q == 2'd3) || (col_q == 2'd3);
  assign indice_d      = ({2'b00, fila_q} * 4'd3) + {2'b00, col_q};
  assign celda_d       = fuera_rango_d ? 9'd0 : (9'd1 << indice_d);
  assign ilegal_d      = fuera_rango_d || (|(celda_d & (tab_x_q | tab_o_q)));

  // The mover's board already contains the new mark when EVALUA looks at it.
  assign tab_mover_d   = turno_q ? tab_o_q : tab_x_q;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lineas
    assign linea_hit_d[gi] = &(tab_mover_d | ~LINEAS[gi*9 +: 9]);
  end
  assign gana_d = |linea_hit_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= ESPERA;
      fila_q      <= 2'd0;
      col_q       <= 2'd0;
      tab_x_q     <= 9'd0;
      tab_o_q     <= 9'd0;
      turno_q     <= PRIMER_TURNO;
      resultado_q <= 2'b00;
      ack_x_q     <= 1'b0;
      ack_o_q     <= 1'b0;
      error_q     <= 1'b0;
      mov_q       <= 4'd0;
    end else if (nuevo_juego) begin
      estado_q    <= ESPERA;
      fila_q      <= 2'd0;
      col_q       <= 2'd0;
      tab_x_q     <= 9'd0;
      tab_o_q     <= 9'd0;
      turno_q     <= PRIMER_TURNO;
      resultado_q <= 2'b00;
      ack_x_q     <= 1'b0;
      ack_o_q     <= 1'b0;
      error_q     <= 1'b0;
      mov_q       <= 4'd0;
    end else begin
      ack_x_q <= 1'b0;
      ack_o_q <= 1'b0;
      error_q <= 1'b0;
      case (estado_q)
        ESPERA: begin
          if (sel_valido_d) begin
            fila_q   <= sel_fila_d;
            col_q    <= sel_col_d;
            ack_x_q  <= ~turno_q;
            ack_o_q  <= turno_q;
            estado_q <= VALIDA;
          end
        end
        VALIDA: begin
          if (ilegal_d) begin
            error_q  <= 1'b1;
            estado_q <= ESPERA;
          end else begin
            estado_q <= ESCRIBE;
          end
        end
        ESCRIBE: begin
          if (turno_q) tab_o_q <= tab_o_q | celda_d;
          else         tab_x_q <= tab_x_q | celda_d;
          if (mov_q != 4'd9) mov_q <= mov_q + 4'd1;
          estado_q <= EVALUA;
        end
        EVALUA: begin
          if (gana_d) begin
            resultado_q <= turno_q ? 2'b10 : 2'b01;
            estado_q    <= FIN;
          end else if (mov_q == 4'd9) begin
            resultado_q <= 2'b11;
            estado_q    <= FIN;
          end else begin
            turno_q  <= ~turno_q;
            estado_q <= ESPERA;
          end
        end
        FIN:     estado_q <= FIN;
        default: estado_q <= ESPERA;
      endcase
    end
  end

  assign jug_x_ack    = ack_x_q;
  assign jug_o_ack    = ack_o_q;
  assign tablero_x    = tab_x_q;
  assign tablero_o    = tab_o_q;
  assign turno        = turno_q;
  assign estado_juego = resultado_q;
  assign error_jugada = error_q;
  assign movimientos  = mov_q;

endmodule

// File: tb/tb_controlador_turnos_gato.sv
// Scoreboarded bench: each move's expected outcome is queued when requested and
// checked once the DUT acknowledges it.
module tb_controlador_turnos_gato;

  logic       clk;
  logic       rst_n;
  logic       nuevo_juego;
  logic       jug_x_valido;
  logic [1:0] jug_x_fila, jug_x_col;
  logic       jug_x_ack;
  logic       jug_o_valido;
  logic [1:0] jug_o_fila, jug_o_col;
  logic       jug_o_ack;
  logic [8:0] tablero_x, tablero_o;
  logic       turno;
  logic [1:0] estado_juego;
  logic       error_jugada;
  logic [3:0] movimientos;

  controlador_turnos_gato #(.PRIMER_TURNO(1'b0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .nuevo_juego  (nuevo_juego),
    .jug_x_valido (jug_x_valido),
    .jug_x_fila   (jug_x_fila),
    .jug_x_col    (jug_x_col),
    .jug_x_ack    (jug_x_ack),
    .jug_o_valido (jug_o_valido),
    .jug_o_fila   (jug_o_fila),
    .jug_o_col    (jug_o_col),
    .jug_o_ack    (jug_o_ack),
    .tablero_x    (tablero_x),
    .tablero_o    (tablero_o),
    .turno        (turno),
    .estado_juego (estado_juego),
    .error_jugada (error_jugada),
    .movimientos  (movimientos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rej;
    logic [8:0] tx;
    logic [8:0] to;
    logic       turno;
    logic [1:0] estado;
    logic [3:0] mov;
  } esperado_t;

  esperado_t cola_x[$];
  esperado_t cola_o[$];

  int total = 0;
  int bad   = 0;

  int acks_x = 0;
  int acks_o = 0;
  int errores = 0;

  logic [8:0] m_x, m_o;
  logic       m_turno;
  logic [1:0] m_est;
  logic [3:0] m_mov;

  always @(negedge clk) begin
    if (jug_x_ack)    acks_x++;
    if (jug_o_ack)    acks_o++;
    if (error_jugada) errores++;
  end

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit gana(input logic [8:0] b);
    bit g;
    g = 1'b0;
    for (int r = 0; r < 3; r++) if (b[3*r] && b[3*r+1] && b[3*r+2]) g = 1'b1;
    for (int c = 0; c < 3; c++) if (b[c] && b[c+3] && b[c+6]) g = 1'b1;
    if (b[0] && b[4] && b[8]) g = 1'b1;
    if (b[2] && b[4] && b[6]) g = 1'b1;
    return g;
  endfunction

  task automatic modelo_reset();
    m_x = 9'd0; m_o = 9'd0; m_turno = 1'b0; m_est = 2'b00; m_mov = 4'd0;
  endtask

  task automatic pedir(input bit p, input logic [1:0] f, input logic [1:0] c);
    esperado_t e;
    int idx;
    e.rej = (f == 2'd3) || (c == 2'd3);
    idx = 0;
    if (!e.rej) begin
      idx = int'(f) * 3 + int'(c);
      if (m_x[idx] || m_o[idx]) e.rej = 1'b1;
    end
    if (!e.rej) begin
      if (p) m_o[idx] = 1'b1; else m_x[idx] = 1'b1;
      m_mov = m_mov + 4'd1;
      if (gana(p ? m_o : m_x))   m_est = p ? 2'b10 : 2'b01;
      else if (m_mov == 4'd9)    m_est = 2'b11;
      else                       m_turno = ~m_turno;
    end
    e.tx = m_x; e.to = m_o; e.turno = m_turno; e.estado = m_est; e.mov = m_mov;
    if (p) begin
      cola_o.push_back(e);
      jug_o_fila = f; jug_o_col = c; jug_o_valido = 1'b1;
    end else begin
      cola_x.push_back(e);
      jug_x_fila = f; jug_x_col = c; jug_x_valido = 1'b1;
    end
  endtask

  task automatic esperar_ack(input bit p, output bit visto);
    visto = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (p ? jug_o_ack : jug_x_ack) begin
        visto = 1'b1;
        break;
      end
    end
    if (p) jug_o_valido = 1'b0; else jug_x_valido = 1'b0;
    if (!visto) comprobar("timeout_ack", 32'd0, 32'd1);
  endtask

  task automatic completar(input bit p);
    esperado_t e;
    bit visto;
    esperar_ack(p, visto);
    if (p ? (cola_o.size() == 0) : (cola_x.size() == 0)) begin
      comprobar("cola_vacia", 32'd0, 32'd1);
      return;
    end
    e = p ? cola_o.pop_front() : cola_x.pop_front();
    if (!visto) return;
    @(negedge clk);
    comprobar("error_jugada", 32'(error_jugada), 32'(e.rej));
    if (!e.rej) begin
      @(negedge clk);
      @(negedge clk);
    end
    comprobar("tablero_x",    32'(tablero_x),    32'(e.tx));
    comprobar("tablero_o",    32'(tablero_o),    32'(e.to));
    comprobar("turno",        32'(turno),        32'(e.turno));
    comprobar("estado_juego", 32'(estado_juego), 32'(e.estado));
    comprobar("movimientos",  32'(movimientos),  32'(e.mov));
    $display("move %s: rej=%0b tx=%09b to=%09b turno=%0b estado=%02b mov=%0d",
             p ? "O" : "X", e.rej, tablero_x, tablero_o, turno, estado_juego, movimientos);
  endtask

  task automatic revisar_reset(input string tag);
    comprobar({tag, "_tx"},     32'(tablero_x),    32'd0);
    comprobar({tag, "_to"},     32'(tablero_o),    32'd0);
    comprobar({tag, "_turno"},  32'(turno),        32'd0);
    comprobar({tag, "_estado"}, 32'(estado_juego), 32'd0);
    comprobar({tag, "_mov"},    32'(movimientos),  32'd0);
    comprobar({tag, "_ack"},    32'({jug_x_ack, jug_o_ack, error_jugada}), 32'd0);
    $display("check %s: tx=%09b to=%09b turno=%0b estado=%02b mov=%0d",
             tag, tablero_x, tablero_o, turno, estado_juego, movimientos);
  endtask

  task automatic pulso_nuevo();
    @(negedge clk);
    nuevo_juego = 1'b1;
    @(negedge clk);
    nuevo_juego = 1'b0;
    modelo_reset();
  endtask

  initial begin
    int ax, ao, er;
    bit visto;
    esperado_t descarte;
    rst_n = 1'b0; nuevo_juego = 1'b0;
    jug_x_valido = 1'b0; jug_x_fila = 2'd0; jug_x_col = 2'd0;
    jug_o_valido = 1'b0; jug_o_fila = 2'd0; jug_o_col = 2'd0;
    modelo_reset();
    repeat (2) @(negedge clk);
    revisar_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    pedir(1'b0, 2'd1, 2'd1); completar(1'b0);
    pedir(1'b1, 2'd1, 2'd1); completar(1'b1);

    // X asserts out of turn; it must stay pending until O has moved.
    jug_x_fila = 2'd0; jug_x_col = 2'd0; jug_x_valido = 1'b1;
    ax = acks_x;
    repeat (6) @(negedge clk);
    comprobar("x_fuera_turno_ack", 32'(acks_x - ax), 32'd0);
    comprobar("x_fuera_turno_tx", 32'(tablero_x), 32'(m_x));
    pedir(1'b1, 2'd0, 2'd1); completar(1'b1);
    comprobar("x_pendiente_ack", 32'(acks_x - ax), 32'd0);
    pedir(1'b0, 2'd0, 2'd0); completar(1'b0);

    pedir(1'b1, 2'd0, 2'd2); completar(1'b1);
    pedir(1'b0, 2'd2, 2'd2); completar(1'b0);

    // Game over: both players ignored.
    ax = acks_x; ao = acks_o; er = errores;
    @(negedge clk);
    jug_x_valido = 1'b1; jug_x_fila = 2'd2; jug_x_col = 2'd0;
    jug_o_valido = 1'b1; jug_o_fila = 2'd2; jug_o_col = 2'd1;
    repeat (8) @(negedge clk);
    jug_x_valido = 1'b0; jug_o_valido = 1'b0;
    comprobar("fin_acks", 32'((acks_x - ax) + (acks_o - ao)), 32'd0);
    comprobar("fin_err", 32'(errores - er), 32'd0);
    comprobar("fin_estado", 32'(estado_juego), 32'd1);
    comprobar("fin_tx", 32'(tablero_x), 32'(m_x));
    $display("fin: estado=%02b acks=%0d", estado_juego, (acks_x - ax) + (acks_o - ao));

    pulso_nuevo();
    revisar_reset("nuevo1");

    pedir(1'b0, 2'd0, 2'd0); completar(1'b0);
    pedir(1'b1, 2'd0, 2'd1); completar(1'b1);
    pedir(1'b0, 2'd0, 2'd2); completar(1'b0);
    pedir(1'b1, 2'd1, 2'd1); completar(1'b1);
    pedir(1'b0, 2'd1, 2'd0); completar(1'b0);
    pedir(1'b1, 2'd1, 2'd2); completar(1'b1);
    pedir(1'b0, 2'd2, 2'd1); completar(1'b0);
    pedir(1'b1, 2'd2, 2'd0); completar(1'b1);
    pedir(1'b0, 2'd2, 2'd2); completar(1'b0);

    pulso_nuevo();
    revisar_reset("nuevo2");
    pedir(1'b0, 2'd3, 2'd0); completar(1'b0);
    pedir(1'b0, 2'd1, 2'd3); completar(1'b0);

    // nuevo_juego while a move is in flight discards it silently.
    pedir(1'b0, 2'd2, 2'd2);
    esperar_ack(1'b0, visto);
    if (cola_x.size() != 0) descarte = cola_x.pop_front();
    er = errores;
    nuevo_juego = 1'b1;
    @(negedge clk);
    nuevo_juego = 1'b0;
    modelo_reset();
    repeat (3) @(negedge clk);
    comprobar("nuevo_vuelo_err", 32'(errores - er), 32'd0);
    revisar_reset("nuevo_vuelo");

    // Asynchronous reset while the move is in ESCRIBE.
    pedir(1'b0, 2'd0, 2'd0);
    esperar_ack(1'b0, visto);
    if (cola_x.size() != 0) descarte = cola_x.pop_front();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    revisar_reset("rst_escribe");
    @(negedge clk);
    revisar_reset("rst_escribe2");
    rst_n = 1'b1;
    modelo_reset();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controlador_turnos_gato.md
Name: controlador_turnos_gato

Overview:
Turn controller and move arbiter for the Gato (tic-tac-toe) board. It accepts move requests from player X and player O, and grants only the player whose turn it is. It validates the target cell and writes the 3x3 occupancy registers. After each move it evaluates win/draw and holds the result until a new game is requested. It sits between the player input registers (row/column values) and the board display logic.

Parameters:
PRIMER_TURNO, 0, player who moves first after reset/new game (0 = X, 1 = O)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
nuevo_juego  input  1  synchronous clear of board and result; sampled every cycle
jug_x_valido  input  1  player X move request, level, held until ack
jug_x_fila  input  2  requested row 0..2 (3 illegal)
jug_x_col  input  2  requested column 0..2 (3 illegal)
jug_x_ack  output  1  one-cycle pulse: X request consumed (legal or not)
jug_o_valido  input  1  player O move request
jug_o_fila  input  2  requested row
jug_o_col  input  2  requested column
jug_o_ack  output  1  one-cycle pulse: O request consumed
tablero_x  output  9  occupancy of X, bit index = fila*3+col
tablero_o  output  9  occupancy of O, same indexing
turno  output  1  player whose move is awaited (0 = X, 1 = O)
estado_juego  output  2  00 playing, 01 X wins, 10 O wins, 11 draw
error_jugada  output  1  one-cycle pulse: rejected move
movimientos  output  4  count of legal moves in current game, 0..9

Behaviour:
- Reset (rst_n low, asynchronous): state ESPERA, tablero_x = tablero_o = 0, turno = PRIMER_TURNO, estado_juego = 00, movimientos = 0, all ack and error outputs = 0.
- All outputs are registered.
- FSM states: ESPERA, VALIDA, ESCRIBE, EVALUA, FIN.
- ESPERA: only the valido of the player matching turno is sampled. The other player's request is ignored: no ack, and it stays pending. If the request is sampled in cycle N, fila/col are latched and the state moves to VALIDA in N+1. The matching ack is high during N+1 only.
- VALIDA: reject if fila==3, col==3, or the cell bit is set in tablero_x|tablero_o. On reject, error_jugada pulses in N+2, the state returns to ESPERA, and turno is unchanged. Otherwise go to ESCRIBE.
- ESCRIBE: set the cell bit in the mover's board and increment movimientos. Both are visible in N+3.
- EVALUA: check the mover's board against 8 lines: rows 0-1-2, 3-4-5, 6-7-8; cols 0-3-6, 1-4-7, 2-5-8; diagonals 0-4-8, 2-4-6.
  - Win: estado_juego = 01 or 10, go to FIN, turno unchanged.
  - Else if movimientos==9: estado_juego = 11, go to FIN.
  - Else: toggle turno, go to ESPERA.
  - A win on the 9th move reports the win, not a draw.
- Legal-move latency from request sample to new turno visible: 4 cycles.
- FIN: requests from both players are ignored (no ack, no error); outputs hold.
- nuevo_juego=1 in any state, mid-operation included: highest priority. Next edge restores reset values except rst_n semantics; any in-flight move is discarded and no ack or error is issued for it.
- Requests are level-based. After an ack, a player still asserting valido in ESPERA on their turn is sampled again. Requesters must drop valido on ack.
- movimientos saturates at 9 (cannot exceed by construction; no wrap).

Test Plan:
- Reset then X requests (1,1) -> jug_x_ack one cycle later; tablero_x=9'b000010000, movimientos=1, turno=1 four cycles after sample.
- O requests (1,1) after X took it -> jug_o_ack then error_jugada pulse; tablero_o=0, turno stays 1, movimientos=1.
- X requests while turno=1 -> no ack, no board change; request accepted after O moves and turno returns to 0.
- X plays 0,4,8 interleaved with O at 1,2 -> estado_juego=01, FIN; further requests get no ack; nuevo_juego clears boards, turno=PRIMER_TURNO.
- Full sequence X:0,2,3,7,8  O:1,4,5,6 -> estado_juego=11, movimientos=9.
- Request with fila=3 -> error_jugada. Then assert rst_n low mid-ESCRIBE -> all outputs immediately return to reset values.
